// File: rtl/rotate_imm_encoder_pkg.sv
// Shared FSM state type and sizing constants for the rotated-immediate encoder.
package rotate_imm_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ROT_STEPS = 16;
  localparam int IMM_WIDTH = 8;
  localparam int ROT_WIDTH = 4;

endpackage

// File: rtl/rotate_imm_encoder_rotl32.sv
// 32-bit rotate-left by a 5-bit amount; purely combinational.
module rotl32 (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  output logic [31:0] dout
);

  logic [63:0] dbl;

  // Shifting the doubled word makes the bits that fall off the top reappear at the bottom.
  assign dbl  = {din, din} << amt;
  assign dout = dbl[63:32];

endmodule

// File: rtl/rotate_imm_encoder.sv
// Searches rot=0..15 one per cycle for value == imm8 ROR (2*rot); done pulses one cycle after the match edge.
// Worst case 16 search cycles; start is ignored while busy and accepted in IDLE or DONE.
module rotate_imm_encoder
  import rotate_imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand
);

  state_t                 state, state_next;
  logic [31:0]            cap;
  logic [ROT_WIDTH-1:0]   rot;
  logic [31:0]            rotated;
  logic                   match;
  logic                   accept;
  logic                   last_rot;

  rotl32 u_rotl32 (
    .din  (cap),
    .amt  ({rot, 1'b0}),
    .dout (rotated)
  );

  assign match    = ~|rotated[31:IMM_WIDTH];
  assign last_rot = (rot == ROT_WIDTH'(ROT_STEPS - 1));
  assign busy     = (state == SEARCH);
  assign done     = (state == DONE);

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (match || last_rot) state_next = DONE;
      end
      DONE: begin
        accept     = start;
        state_next = start ? SEARCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap           <= '0;
      rot           <= '0;
      found         <= 1'b0;
      shift_operand <= '0;
    end else if (accept) begin
      cap <= value;
      rot <= '0;
    end else if (state == SEARCH) begin
      if (match) begin
        found         <= 1'b1;
        shift_operand <= {rot, rotated[IMM_WIDTH-1:0]};
      end else if (last_rot) begin
        found         <= 1'b0;
        shift_operand <= '0;
      end else begin
        rot <= rot + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rotate_imm_encoder.sv
// Scoreboard bench: expected results queued at start, popped and compared on each done pulse.
module tb_rotate_imm_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] shift_operand;

  typedef struct {
    bit          f;
    logic [11:0] so;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_err;

  rotate_imm_encoder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .shift_operand (shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: lowest even right-rotation of an 8-bit immediate that reproduces v.
  task automatic model(input logic [31:0] v, output bit f, output logic [11:0] so, output int r);
    logic [31:0] t;
    f  = 1'b0;
    so = '0;
    r  = 15;
    for (int k = 0; k < 16; k++) begin
      t = (k == 0) ? v : ((v << (2 * k)) | (v >> (32 - 2 * k)));
      if (t[31:8] == 24'd0) begin
        f  = 1'b1;
        so = {k[3:0], t[7:0]};
        r  = k;
        break;
      end
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] v, input int s);
    return (s == 0) ? v : ((v >> s) | (v << (32 - s)));
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("found", 32'(found), 32'(e.f));
        chk("shift_operand", 32'(shift_operand), 32'(e.so));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0 && !done) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask

  task automatic run(input logic [31:0] v, input bit ef, input logic [11:0] eso, input int er);
    @(negedge clk);
    value = v;
    start = 1'b1;
    q.push_back('{ef, eso, cyc + er + 2});
    @(negedge clk);
    start = 1'b0;
    value = $urandom;
    chk("busy_search", 32'(busy), 32'd1);
    drain();
    @(negedge clk);
    @(negedge clk);
    chk("hold_found", 32'(found), 32'(ef));
    chk("hold_shift_operand", 32'(shift_operand), 32'(eso));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_model(input logic [31:0] v);
    bit          f;
    logic [11:0] so;
    int          r;
    model(v, f, so, r);
    run(v, f, so, r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_shift_operand", 32'(shift_operand), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run(32'h0000_00FF, 1'b1, 12'h0FF, 0);
    run(32'hFF00_0000, 1'b1, 12'h4FF, 4);
    run(32'h0000_03FC, 1'b1, 12'hFFF, 15);
    run(32'hF000_000F, 1'b1, 12'h2FF, 2);
    run(32'h0000_0101, 1'b0, 12'h000, 15);
    run(32'h0000_0000, 1'b1, 12'h000, 0);
    run(32'h0000_0101, 1'b0, 12'h000, 15);

    // start and value wiggle during SEARCH must not disturb the running search
    @(negedge clk);
    value = 32'h0000_03FC;
    start = 1'b1;
    q.push_back('{1'b1, 12'hFFF, cyc + 17});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = i[0];
      value = $urandom;
    end
    start = 1'b0;
    drain();

    // start held through DONE: second request accepted in the DONE cycle
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      value = 32'hFF00_0000;
      start = 1'b1;
      q.push_back('{1'b1, 12'h4FF, cyc + 6});
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("b2b_first_done_seen", 32'(seen), 32'd1);
      value = 32'hF000_000F;
      q.push_back('{1'b1, 12'h2FF, cyc + 4});
      @(negedge clk);
      start = 1'b0;
      chk("b2b_second_busy", 32'(busy), 32'd1);
      drain();
    end

    // reset mid-search: no done pulse, outputs cleared
    @(negedge clk);
    value = 32'h0000_FF00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_found", 32'(found), 32'd0);
    chk("abort_shift_operand", 32'(shift_operand), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    run(32'h0000_00FF, 1'b1, 12'h0FF, 0);
    run_model(32'h0000_FF00);

    for (int i = 0; i < 6; i++) begin
      run_model(ror32(32'($urandom_range(1, 255)), 2 * $urandom_range(0, 15)));
      run_model($urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
